// File: rtl/cordic_vectoring_iter.sv
// -----------------------------------------------------------------------------
// cordic_vectoring_iter
// Iterative single-stage CORDIC in vectoring mode. A Cartesian vector (x, y)
// is rotated onto the positive x axis by NUM_STAGES shift/add micro-rotations
// through one shared datapath. The accumulated rotation is atan2(y, x) as a
// binary angle (2^WIDTH = 360 deg). The final x is the gain-scaled magnitude.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset (dominates valid_in)
//   valid_in   in   sample strobe, accepted only when ready is high
//   x_in,y_in  in   WIDTH-bit signed two's-complement vector
//   ready      out  high only while idle and able to accept
//   valid_out  out  one-cycle result pulse
//   angle      out  WIDTH-bit signed binary angle, held between pulses
//   mag        out  WIDTH+1-bit unsigned magnitude * K (uncompensated)
// -----------------------------------------------------------------------------
module cordic_vectoring_iter #(
    parameter int NUM_STAGES = 12,
    parameter int WIDTH      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    output logic             ready,
    output logic             valid_out,
    output logic [WIDTH-1:0] angle,
    output logic [WIDTH:0]   mag
);

    // x/y need two guard bits: sqrt(2) * K < 2.4 for |x|,|y| <= 2^(WIDTH-1).
    localparam int XW = WIDTH + 2;
    localparam int ZW = WIDTH + 1;
    localparam int CW = $clog2(NUM_STAGES + 1);

    // +90 deg in the binary angle format.
    localparam logic signed [ZW-1:0] Z_QUARTER = {2'b00, 1'b1, {(WIDTH-2){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_t;

    // atan(2^-i) in 2^32-per-turn units, rounded once down to WIDTH bits.
    // Beyond the table atan(2^-i) == 2^-i to well under one 2^-32 turn.
    function automatic logic [WIDTH-1:0] atan_lut(input logic [5:0] idx);
        logic [31:0] t32;
        case (idx)
            6'd0:    t32 = 32'h2000_0000;
            6'd1:    t32 = 32'h12E4_051E;
            6'd2:    t32 = 32'h09FB_385B;
            6'd3:    t32 = 32'h0511_11D4;
            6'd4:    t32 = 32'h028B_0D43;
            6'd5:    t32 = 32'h0145_D7E1;
            6'd6:    t32 = 32'h00A2_F61E;
            6'd7:    t32 = 32'h0051_7C55;
            6'd8:    t32 = 32'h0028_BE53;
            6'd9:    t32 = 32'h0014_5F2F;
            6'd10:   t32 = 32'h000A_2F98;
            6'd11:   t32 = 32'h0005_17CC;
            6'd12:   t32 = 32'h0002_8BE6;
            6'd13:   t32 = 32'h0001_45F3;
            6'd14:   t32 = 32'h0000_A2FA;
            6'd15:   t32 = 32'h0000_517D;
            6'd16:   t32 = 32'h0000_28BE;
            6'd17:   t32 = 32'h0000_145F;
            6'd18:   t32 = 32'h0000_0A30;
            6'd19:   t32 = 32'h0000_0518;
            default: t32 = 32'd683565276 >> idx;
        endcase
        atan_lut = WIDTH'(({1'b0, t32} + (33'd1 << (31 - WIDTH))) >> (32 - WIDTH));
    endfunction

    state_t                 state_q, state_d;
    logic signed [XW-1:0]   x_q, x_d, y_q, y_d;
    logic signed [ZW-1:0]   z_q, z_d;
    logic [CW-1:0]          iter_q, iter_d;
    logic                   zero_q, zero_d;
    logic                   ready_q, ready_d;
    logic                   valid_out_q, valid_out_d;
    logic [WIDTH-1:0]       angle_q, angle_d;
    logic [WIDTH:0]         mag_q, mag_d;

    logic                   accept;
    logic signed [XW-1:0]   x_sh, y_sh;
    logic signed [ZW-1:0]   atan_s;

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        iter_d      = iter_q;
        zero_d      = zero_q;
        valid_out_d = 1'b0;
        angle_d     = angle_q;
        mag_d       = mag_q;
        accept      = valid_in && ready_q;
        x_sh        = x_q >>> iter_q;
        y_sh        = y_q >>> iter_q;
        atan_s      = {1'b0, atan_lut(6'(iter_q))};

        case (state_q)
            IDLE: begin
                if (accept) begin
                    x_d     = {{2{x_in[WIDTH-1]}}, x_in};
                    y_d     = {{2{y_in[WIDTH-1]}}, y_in};
                    state_d = PRE;
                end else begin
                    state_d = IDLE;
                end
            end
            PRE: begin
                // Fold the left half-plane into the right one by +/-90 deg so
                // the micro-rotations (about +/-100 deg total) can converge.
                zero_d = (x_q == '0) && (y_q == '0);
                iter_d = '0;
                if (x_q[XW-1] && !y_q[XW-1]) begin
                    x_d = y_q;
                    y_d = -x_q;
                    z_d = Z_QUARTER;
                end else if (x_q[XW-1]) begin
                    x_d = -y_q;
                    y_d = x_q;
                    z_d = -Z_QUARTER;
                end else begin
                    z_d = '0;
                end
                state_d = ITER;
            end
            ITER: begin
                // Rotate toward y = 0; all three updates use old values.
                if (!y_q[XW-1]) begin
                    x_d = x_q + y_sh;
                    y_d = y_q - x_sh;
                    z_d = z_q + atan_s;
                end else begin
                    x_d = x_q - y_sh;
                    y_d = y_q + x_sh;
                    z_d = z_q - atan_s;
                end
                if (iter_q == CW'(NUM_STAGES - 1)) begin
                    state_d = DONE;
                end else begin
                    iter_d = iter_q + 1'b1;
                end
            end
            DONE: begin
                valid_out_d = 1'b1;
                // z wraps modulo one turn, so +180 deg reads as -2^(WIDTH-1).
                if (zero_q) begin
                    angle_d = '0;
                    mag_d   = '0;
                end else begin
                    angle_d = z_q[WIDTH-1:0];
                    mag_d   = x_q[WIDTH:0];
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // ready is registered: it drops on the accepting edge and comes back
        // one cycle after the result pulse.
        ready_d = (state_q == IDLE) && !accept;
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            iter_q      <= '0;
            zero_q      <= 1'b0;
            ready_q     <= 1'b1;
            valid_out_q <= 1'b0;
            angle_q     <= '0;
            mag_q       <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            iter_q      <= iter_d;
            zero_q      <= zero_d;
            ready_q     <= ready_d;
            valid_out_q <= valid_out_d;
            angle_q     <= angle_d;
            mag_q       <= mag_d;
        end
    end

    assign ready     = ready_q;
    assign valid_out = valid_out_q;
    assign angle     = angle_q;
    assign mag       = mag_q;

endmodule
